// File: rtl/shiftreg_pkg.sv
// Shared defaults and helpers for the shiftreg_4bit serial shift register.
package shiftreg_pkg;

    localparam int SHIFTREG_DEPTH_DEF = 4;

    // Width that can hold every value from 0 to depth inclusive.
    function automatic int fill_cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/shiftreg_4bit_dff_sclr.sv
// Single-bit D flop with synchronous active-high clear; one stage of the shift chain.
module dff_sclr (
    input  logic clk,
    input  logic clr,
    input  logic d,
    output logic q
);

    always_ff @(posedge clk) begin
        if (clr) begin
            q <= 1'b0;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/shiftreg_4bit.sv
// Serial-in/serial-out shift register of DEPTH stages with synchronous clear.
// Optional fill status (full port and counter) enabled by SHIFTREG_FILL_STATUS_EN.
module shiftreg_4bit
    import shiftreg_pkg::*;
#(
    parameter int DEPTH = SHIFTREG_DEPTH_DEF
) (
    input  logic a,
    output logic e,
    input  logic clk,
    input  logic clr
`ifdef SHIFTREG_FILL_STATUS_EN
    ,
    output logic full
`endif
);

    logic [DEPTH-1:0] q;
    logic [DEPTH-1:0] d;

    // Stage 0 takes the serial input; every later stage takes its predecessor.
    assign d = {q[DEPTH-2:0], a};

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        dff_sclr u_stage (
            .clk (clk),
            .clr (clr),
            .d   (d[i]),
            .q   (q[i])
        );
    end

    assign e = q[DEPTH-1];

`ifdef SHIFTREG_FILL_STATUS_EN
    localparam int CW = fill_cnt_width(DEPTH);
    localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);

    logic [CW-1:0] count;
    logic [CW-1:0] count_nxt;

    always_comb begin
        count_nxt = count;
        if (count != DEPTH_CNT) begin
            count_nxt = count + 1'b1;
        end
    end

    // full is registered from the next count so it rises on the DEPTH-th edge.
    always_ff @(posedge clk) begin
        if (clr) begin
            count <= '0;
            full  <= 1'b0;
        end else begin
            count <= count_nxt;
            full  <= (count_nxt == DEPTH_CNT);
        end
    end
`endif

endmodule

// File: tb/tb_shiftreg_4bit.sv
// Directed testbench for shiftreg_4bit at DEPTH=4 (covers SHIFTREG_FILL_STATUS_EN when defined).
module tb_shiftreg_4bit;

    logic clk;
    logic clr;
    logic a;
    logic e;
`ifdef SHIFTREG_FILL_STATUS_EN
    logic full;
`endif

    int n_cmp;
    int n_bad;

    logic [3:0] mdl_q;
    int         mdl_cnt;

    shiftreg_4bit #(.DEPTH(4)) dut (
        .a   (a),
        .e   (e),
        .clk (clk),
        .clr (clr)
`ifdef SHIFTREG_FILL_STATUS_EN
        ,
        .full(full)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and update the reference model with the driven inputs.
    task automatic step();
        logic a_s;
        logic clr_s;
        a_s   = a;
        clr_s = clr;
        @(posedge clk);
        #1;
        if (clr_s) begin
            mdl_q   = 4'b0000;
            mdl_cnt = 0;
        end else begin
            mdl_q = {mdl_q[2:0], a_s};
            if (mdl_cnt < 4) mdl_cnt++;
        end
    endtask

    task automatic check_full(input string tag, input logic exp);
`ifdef SHIFTREG_FILL_STATUS_EN
        check(tag, {31'd0, full}, {31'd0, exp});
`else
        if (exp === 1'bz) $display("unused %s", tag);
`endif
    endtask

    task automatic reset_dut();
        clr = 1'b1;
        a   = 1'b1;
        step();
        clr = 1'b0;
    endtask

    logic seq_a [12] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic seq_e [12] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

    initial begin
        logic       e_hold;
        logic [3:0] q_hold;
        n_cmp   = 0;
        n_bad   = 0;
        mdl_q   = 4'bxxxx;
        mdl_cnt = 0;
        clr     = 1'b0;
        a       = 1'b0;
        @(negedge clk);

        // Reset with a=1 driven: must be ignored.
        reset_dut();
        check("rst_e", {31'd0, e}, 32'd0);
        check("rst_q", {28'd0, dut.q}, 32'd0);
        check_full("rst_full", 1'b0);

        // Serial pattern with 3-cycle delay to the output.
        for (int k = 0; k < 12; k++) begin
            a = seq_a[k];
            step();
            check($sformatf("seq_e[%0d]", k), {31'd0, e}, {31'd0, seq_e[k]});
            check($sformatf("seq_q[%0d]", k), {28'd0, dut.q}, {28'd0, mdl_q});
        end

        // Fill with ones: full rises exactly on the 4th edge.
        reset_dut();
        for (int k = 0; k < 4; k++) begin
            a = 1'b1;
            step();
            check_full($sformatf("fill1_full[%0d]", k), (k == 3) ? 1'b1 : 1'b0);
        end
        check("fill1_q", {28'd0, dut.q}, 32'hF);
        check("fill1_e", {31'd0, e}, 32'd1);

        // Load q=1011 then clear mid-stream.
        a = 1'b1; step();
        a = 1'b0; step();
        a = 1'b1; step();
        a = 1'b1; step();
        check("load_q", {28'd0, dut.q}, 32'hB);
        clr = 1'b1;
        a   = 1'b1;
        step();
        clr = 1'b0;
        check("midclr_q", {28'd0, dut.q}, 32'd0);
        check("midclr_e", {31'd0, e}, 32'd0);
        check_full("midclr_full", 1'b0);
        for (int k = 0; k < 4; k++) begin
            a = 1'b1;
            step();
            check_full($sformatf("refill_full[%0d]", k), (k == 3) ? 1'b1 : 1'b0);
        end
        check("refill_q", {28'd0, dut.q}, 32'hF);

        // Toggle a between edges: no combinational path to e.
        a = 1'b0; step(); step(); step();
        check("pre_tog_q", {28'd0, dut.q}, 32'h8);
        e_hold = e;
        q_hold = dut.q;
        for (int k = 0; k < 4; k++) begin
            a = ~a;
            #1;
            check($sformatf("tog_e[%0d]", k), {31'd0, e}, {31'd0, e_hold});
        end
        check("tog_q", {28'd0, dut.q}, {28'd0, q_hold});

        // clr pulse not spanning an edge has no effect.
        a = 1'b1;
        step();
        q_hold = dut.q;
        check("pre_pulse_q", {28'd0, q_hold}, {28'd0, mdl_q});
        #1 clr = 1'b1;
        #2 clr = 1'b0;
        #1;
        check("pulse_q", {28'd0, dut.q}, {28'd0, q_hold});
        check("pulse_e", {31'd0, e}, {31'd0, q_hold[3]});
        a = 1'b0;
        step();
        check("post_pulse_q", {28'd0, dut.q}, 32'h2);

        // X on input propagates to e after 4 edges.
        a = 1'bx;
        step();
        a = 1'b0;
        step(); step(); step();
        check("xprop_e", {31'd0, e}, {31'd0, 1'bx});
        step();
        check("xprop_out_e", {31'd0, e}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/shiftreg_4bit.md
SHIFTREG_4BIT -- requirements
Module: shiftreg_4bit

Interface
REQ-001 Parameter: DEPTH, default 4, number of shift stages (legal range 2..32).
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: clr  input  1  reset, synchronous, active-high; sampled on rising clk.
REQ-004 Port: a  input  1  serial data in.
REQ-005 Port: e  output  1  serial data out, the last stage of the register.
REQ-006 Positional port order SHALL be a, e, clk, clr; existing positional instantiations depend on this order.
REQ-007 With SHIFTREG_FILL_STATUS_EN defined, one extra port SHALL follow clr: full  output  1  high once DEPTH bits have been shifted in since the last reset.

Function
REQ-008 Internal state SHALL be a DEPTH-bit register q[0..DEPTH-1].
REQ-009 On a rising clk edge with clr=0: q[0] <= a, and q[i] <= q[i-1] for every i from 1 to DEPTH-1.
REQ-010 e SHALL equal q[DEPTH-1] directly from a flop, with no combinational path from a to e.
REQ-011 Latency: a value of a sampled at edge k SHALL appear on e after edge k+DEPTH-1, i.e. after the 4th sampling edge at DEPTH=4.
REQ-012 There is no enable; the register shifts on every edge where clr=0.
REQ-013 Before the first reset, q and e are unspecified (X in simulation); no power-on value is required.
REQ-014 An X on a SHALL propagate through the stages unchanged; no X-masking.

Reset
REQ-015 On a rising clk edge with clr=1, all q bits SHALL become 0, so e=0 after that edge.
REQ-016 clr takes priority over shifting; a is ignored on any edge where clr=1.
REQ-017 Reset mid-stream SHALL discard all stored bits; shifting resumes from an all-zero state on the first edge with clr=0.
REQ-018 clr SHALL have no asynchronous effect; a clr pulse that does not span a rising edge has no effect.

Configuration
REQ-019 Macro SHIFTREG_FILL_STATUS_EN: when defined, the block SHALL contain a saturating fill counter of width clog2(DEPTH+1).
- Counter clears on clr and increments on each non-reset edge up to DEPTH.
- full = (count == DEPTH), registered.
REQ-020 Without SHIFTREG_FILL_STATUS_EN, the full port and the counter SHALL be absent, and behaviour is exactly REQ-008..REQ-018.

Structure
REQ-021 Package shiftreg_pkg SHALL hold the DEPTH default (SHIFTREG_DEPTH_DEF = 4) and the counter-width function.
REQ-022 Sub-module dff_sclr (1-bit D flop with synchronous active-high clear) SHALL be instantiated DEPTH times in a generate chain.
REQ-023 The top level holds only the chaining, the e assignment and the optional fill counter.

Verification (DEPTH=4, clk period 10 ns)
REQ-024 Hold clr=1 across one edge, then set clr=0 -> e=0 and q=0000 after that edge; with SHIFTREG_FILL_STATUS_EN defined, full=0.
REQ-025 After reset, drive a = 1,1,0,1,0,1,0,1,0 on successive edges -> e = 1,1,0,1,0,1,0,1,0, starting 3 cycles after the first bit, one bit per cycle.
REQ-026 Drive a=1 for 4 edges after reset -> q=1111 and e=1; with SHIFTREG_FILL_STATUS_EN defined, full rises exactly on the 4th edge.
REQ-027 Assert clr=1 for one edge while q=1011 -> q=0000 next edge, a ignored; with SHIFTREG_FILL_STATUS_EN defined, full=0 and refill needs 4 more edges.
REQ-028 Toggle a between edges with clr=0 and no clock edge in between -> e unchanged (no combinational path).
REQ-029 Pulse clr=1 between edges only -> state unchanged (synchronous reset).
